// File: rtl/sp_window_ctrl.sv
// sp_window_ctrl: measurement-window controller for the instruction
// switching-activity datapath. One window per accepted start: a single PRIME
// cycle discards the stale activity word, then ACCUM sums i_sp over valid
// instructions until the latched length is reached or i_stop aborts. The
// total is offered in HOLD through a valid/ready handshake.
// Optional build macro: SP_PEAK_EN adds a running maximum of accumulated i_sp
// on o_peak; without it o_peak is constant zero and no peak logic exists.
module sp_window_ctrl #(
    parameter int unsigned W_SP  = 32,
    parameter int unsigned W_ACC = 48,
    parameter int unsigned W_LEN = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [W_LEN-1:0] i_win_len,
    input  logic [W_SP-1:0]  i_sp,
    input  logic             i_sp_vld,
    input  logic             i_ready,
    output logic             o_busy,
    output logic             o_valid,
    output logic [W_ACC-1:0] o_acc,
    output logic [W_LEN-1:0] o_cnt,
    output logic             o_abort,
    output logic             o_sat,
    output logic [W_SP-1:0]  o_peak
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRIME = 2'd1;
    localparam logic [1:0] S_ACCUM = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // One extra bit over the wider operand so the carry out of the
    // accumulator is always visible, even when W_SP exceeds W_ACC.
    localparam int unsigned W_SUM = ((W_ACC > W_SP) ? W_ACC : W_SP) + 1;

    logic [1:0]       state;
    logic [W_LEN-1:0] len_q;
    logic [W_ACC-1:0] acc_q;
    logic [W_LEN-1:0] cnt_q;
    logic             abort_q;
    logic             sat_q;

    logic             start_ok;
    logic             launch;
    logic [W_SUM-1:0] sum;
    logic             sum_ovf;
    logic [W_LEN-1:0] cnt_inc;
    logic             last_smp;

    // Start qualification, saturating adder and window-completion detect.
    always_comb begin
        start_ok = i_start && (i_win_len != '0);
        launch   = start_ok && ((state == S_IDLE) || ((state == S_HOLD) && i_ready));
        sum      = W_SUM'(acc_q) + W_SUM'(i_sp);
        sum_ovf  = |(sum >> W_ACC);
        cnt_inc  = cnt_q + W_LEN'(1);
        last_smp = i_sp_vld && (cnt_inc == len_q);
    end

    // Window sequencing and accumulation; a launch from IDLE or from a
    // completed handshake in HOLD shares the same clear-and-latch path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            len_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            sat_q   <= 1'b0;
        end else if (launch) begin
            state   <= S_PRIME;
            len_q   <= i_win_len;
            acc_q   <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            case (state)
                S_PRIME: begin
                    if (i_stop) begin
                        state   <= S_HOLD;
                        abort_q <= 1'b1;
                    end else begin
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (i_sp_vld) begin
                        acc_q <= sum_ovf ? '1 : sum[W_ACC-1:0];
                        sat_q <= sat_q | sum_ovf;
                        cnt_q <= cnt_inc;
                    end
                    if (last_smp) begin
                        state <= S_HOLD;
                    end else if (i_stop) begin
                        state   <= S_HOLD;
                        abort_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (i_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SP_PEAK_EN
    logic [W_SP-1:0] peak_q;

    // Running maximum over samples that are actually accumulated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else if (launch) begin
            peak_q <= '0;
        end else if ((state == S_ACCUM) && i_sp_vld && (i_sp > peak_q)) begin
            peak_q <= i_sp;
        end
    end

    assign o_peak = peak_q;
`else
    assign o_peak = '0;
`endif

    assign o_busy  = (state == S_PRIME) || (state == S_ACCUM);
    assign o_valid = (state == S_HOLD);
    assign o_acc   = acc_q;
    assign o_cnt   = cnt_q;
    assign o_abort = abort_q;
    assign o_sat   = sat_q;

endmodule

// File: tb/tb_sp_window_ctrl.sv
// Scoreboard bench for sp_window_ctrl. Two instances share one stimulus
// stream: the default-width DUT and a narrow-accumulator (W_ACC=8) copy that
// exercises saturation. Each window pushes its hand-computed result for both;
// a monitor pops and compares on every rising o_valid.
module tb_sp_window_ctrl;

    localparam int unsigned W_SP  = 32;
    localparam int unsigned W_ACC = 48;
    localparam int unsigned W_LEN = 16;

    logic             clk;
    logic             rst_n;
    logic             i_start;
    logic             i_stop;
    logic [W_LEN-1:0] i_win_len;
    logic [W_SP-1:0]  i_sp;
    logic             i_sp_vld;
    logic             i_ready;

    logic             o_busy, o_valid, o_abort, o_sat;
    logic [W_ACC-1:0] o_acc;
    logic [W_LEN-1:0] o_cnt;
    logic [W_SP-1:0]  o_peak;

    logic             s_busy, s_valid, s_abort, s_sat;
    logic [7:0]       s_acc;
    logic [W_LEN-1:0] s_cnt;
    logic [W_SP-1:0]  s_peak;

    typedef struct {
        longint unsigned acc;
        int unsigned     cnt;
        bit              abort;
        bit              sat;
        int unsigned     peak;
    } exp_t;

    exp_t q_main[$];
    exp_t q_small[$];

    int n_checks = 0;
    int n_fail   = 0;

    sp_window_ctrl #(.W_SP(W_SP), .W_ACC(W_ACC), .W_LEN(W_LEN)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_win_len(i_win_len), .i_sp(i_sp), .i_sp_vld(i_sp_vld), .i_ready(i_ready),
        .o_busy(o_busy), .o_valid(o_valid), .o_acc(o_acc), .o_cnt(o_cnt),
        .o_abort(o_abort), .o_sat(o_sat), .o_peak(o_peak)
    );

    sp_window_ctrl #(.W_SP(W_SP), .W_ACC(8), .W_LEN(W_LEN)) u_small (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_win_len(i_win_len), .i_sp(i_sp), .i_sp_vld(i_sp_vld), .i_ready(i_ready),
        .o_busy(s_busy), .o_valid(s_valid), .o_acc(s_acc), .o_cnt(s_cnt),
        .o_abort(s_abort), .o_sat(s_sat), .o_peak(s_peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected result for both instances; peak only exists with SP_PEAK_EN.
    task automatic push(input longint unsigned acc, input int unsigned cnt, input bit abort,
                        input bit sat, input int unsigned peak,
                        input longint unsigned acc8, input bit sat8);
        exp_t e;
        int unsigned pk;
`ifdef SP_PEAK_EN
        pk = peak;
`else
        pk = 0;
`endif
        e = '{acc: acc, cnt: cnt, abort: abort, sat: sat, peak: pk};
        q_main.push_back(e);
        e.acc = acc8;
        e.sat = sat8;
        q_small.push_back(e);
    endtask

    // Monitor: compare on the first cycle of each presented result.
    initial begin
        bit   prev_m = 1'b0;
        bit   prev_s = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_m = 1'b0;
                prev_s = 1'b0;
            end else begin
                if (o_valid && !prev_m) begin
                    if (q_main.size() == 0) begin
                        chk("main_unexpected_result", 1, 0);
                    end else begin
                        e = q_main.pop_front();
                        chk("main_acc",   o_acc,   e.acc);
                        chk("main_cnt",   o_cnt,   e.cnt);
                        chk("main_abort", o_abort, e.abort);
                        chk("main_sat",   o_sat,   e.sat);
                        chk("main_peak",  o_peak,  e.peak);
                    end
                end
                if (s_valid && !prev_s) begin
                    if (q_small.size() == 0) begin
                        chk("small_unexpected_result", 1, 0);
                    end else begin
                        e = q_small.pop_front();
                        chk("small_acc",   s_acc,   e.acc);
                        chk("small_cnt",   s_cnt,   e.cnt);
                        chk("small_abort", s_abort, e.abort);
                        chk("small_sat",   s_sat,   e.sat);
                        chk("small_peak",  s_peak,  e.peak);
                    end
                end
                prev_m = o_valid;
                prev_s = s_valid;
            end
        end
    end

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_win_len = '0;
        i_sp = '0; i_sp_vld = 1'b0; i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  o_busy,  0);
        chk("rst_valid", o_valid, 0);
        chk("rst_acc",   o_acc,   0);
        chk("rst_cnt",   o_cnt,   0);
        chk("rst_abort", o_abort, 0);
        chk("rst_sat",   o_sat,   0);
        chk("rst_peak",  o_peak,  0);
        rst_n = 1'b1;
        tick;

        // Basic window with latency check: len=4, i_sp=10.
        push(40, 4, 0, 0, 10, 40, 0);
        i_win_len = 4; i_sp = 10; i_sp_vld = 1; i_start = 1;
        tick;
        i_start = 0;
        chk("basic_busy_prime", o_busy, 1);
        repeat (4) tick;
        chk("basic_valid_early", o_valid, 0);
        tick;
        chk("basic_valid", o_valid, 1);
        tick;
        chk("basic_valid_drop", o_valid, 0);
        chk("basic_idle_busy", o_busy, 0);
        i_sp_vld = 0;

        // PRIME discard and vld gating: 100 in PRIME, then 1, (7 invalid), 3, 4.
        push(8, 3, 0, 0, 4, 8, 0);
        i_win_len = 3; i_start = 1;
        tick;
        i_start = 0; i_sp = 100; i_sp_vld = 1;
        tick;
        i_sp = 1; tick;
        i_sp = 7; i_sp_vld = 0; tick;
        i_sp = 3; i_sp_vld = 1; tick;
        i_sp = 4; tick;
        i_sp_vld = 0;
        tick;

        // Abort after 3 valid samples of 5.
        push(15, 3, 1, 0, 5, 15, 0);
        i_win_len = 10; i_sp = 5; i_sp_vld = 1; i_start = 1;
        tick;
        i_start = 0;
        tick;
        repeat (3) tick;
        i_sp_vld = 0; i_stop = 1;
        tick;
        i_stop = 0;
        tick;

        // Stop coincident with the 10th sample: completion wins.
        push(50, 10, 0, 0, 5, 50, 0);
        i_sp_vld = 1; i_start = 1;
        tick;
        i_start = 0;
        tick;
        repeat (9) tick;
        i_stop = 1;
        tick;
        i_stop = 0; i_sp_vld = 0;
        tick;

        // Stop during PRIME: empty aborted result.
        push(0, 0, 1, 0, 0, 0, 0);
        i_start = 1;
        tick;
        i_start = 0; i_stop = 1;
        tick;
        i_stop = 0;
        chk("prime_stop_valid", o_valid, 1);
        tick;

        // Saturation on the 8-bit instance: 200+200.
        push(400, 2, 0, 0, 200, 255, 1);
        i_win_len = 2; i_sp = 200; i_sp_vld = 1; i_start = 1;
        tick;
        i_start = 0;
        repeat (3) tick;
        i_sp_vld = 0;
        tick;

        // Minimum window (len=1): sat flag cleared by the new start.
        push(7, 1, 0, 0, 7, 7, 0);
        i_win_len = 1; i_sp = 7; i_sp_vld = 1; i_start = 1;
        tick;
        i_start = 0;
        tick;
        tick;
        chk("len1_valid", o_valid, 1);
        i_sp_vld = 0;
        tick;

        // Handshake stall, ignored start in HOLD, then back-to-back launch.
        push(6, 2, 0, 0, 3, 6, 0);
        push(8, 2, 0, 0, 4, 8, 0);
        i_ready = 0; i_win_len = 2; i_sp = 3; i_sp_vld = 1; i_start = 1;
        tick;
        i_start = 0;
        repeat (3) tick;
        i_sp_vld = 0; i_sp = 4;
        for (int i = 0; i < 5; i++) begin
            i_start = 1; i_win_len = 5;
            tick;
            chk("hold_valid", o_valid, 1);
            chk("hold_acc",   o_acc,   6);
            chk("hold_cnt",   o_cnt,   2);
            chk("hold_busy",  o_busy,  0);
        end
        i_ready = 1; i_win_len = 2; i_sp_vld = 1;
        tick;
        i_start = 0;
        chk("b2b_valid_drop", o_valid, 0);
        chk("b2b_busy", o_busy, 1);
        tick;
        tick;
        chk("b2b_valid_early", o_valid, 0);
        tick;
        chk("b2b_valid", o_valid, 1);
        i_sp_vld = 0;
        tick;

        // Zero-length start is ignored.
        i_win_len = 0; i_start = 1;
        tick;
        i_start = 0;
        chk("len0_busy",  o_busy,  0);
        chk("len0_valid", o_valid, 0);
        tick;
        chk("len0_busy2", o_busy, 0);

        // Peak: 50 in PRIME excluded, then 3, 9, 4.
        push(16, 3, 0, 0, 9, 16, 0);
        i_win_len = 3; i_start = 1;
        tick;
        i_start = 0; i_sp = 50; i_sp_vld = 1;
        tick;
        i_sp = 3; tick;
        i_sp = 9; tick;
        i_sp = 4; tick;
        i_sp_vld = 0;
        tick;

        // Reset mid-ACCUM: outputs clear immediately, no result follows.
        i_win_len = 5; i_sp = 2; i_sp_vld = 1; i_start = 1;
        tick;
        i_start = 0;
        repeat (3) tick;
        rst_n = 0;
        #1;
        chk("mid_rst_busy",  o_busy,  0);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_acc",   o_acc,   0);
        chk("mid_rst_cnt",   o_cnt,   0);
        chk("mid_rst_abort", o_abort, 0);
        chk("mid_rst_sat",   o_sat,   0);
        chk("mid_rst_peak",  o_peak,  0);
        chk("mid_rst_sacc",  s_acc,   0);
        rst_n = 1;
        repeat (8) tick;
        chk("post_rst_valid", o_valid, 0);
        chk("post_rst_busy",  o_busy,  0);
        i_sp_vld = 0;
        tick;

        chk("main_queue_drained",  q_main.size(),  0);
        chk("small_queue_drained", q_small.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
